// File: rtl/nibble_serial_adder_if.sv
// Valid/ready bundle for nibble_serial_adder: operand handshake in, result handshake out.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder streaming WIDTH-bit operands through one 4-bit carry-lookahead slice.
// Optional signed-overflow flag enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module carry_look_ahead_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                reset,
  nibble_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [N-1:0][3:0]    a_reg;
  logic [N-1:0][3:0]    b_reg;
  logic [N-1:0][3:0]    sum_reg;
  logic                 carry;
  logic [KW-1:0]        k;
  logic                 last;
  logic [3:0]           slice_sum;
  logic                 slice_co;

  assign last = (k == KW'(N - 1));

  carry_look_ahead_adder_4bit u_slice (
    .a     (a_reg[k]),
    .b     (b_reg[k]),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_co)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = BUSY;
      BUSY:    if (last)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Upper sum nibbles keep the previous result until the slice overwrites them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.c_in;
            k     <= '0;
          end
        end
        BUSY: begin
          sum_reg[k] <= slice_sum;
          carry      <= slice_co;
          if (!last) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_reg;
  assign bus.c_out     = carry;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // Carry into the MSB is recovered from the MSB sum bit, then compared with the carry out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     ovf_reg <= 1'b0;
    else if (state == BUSY && last) ovf_reg <= a_reg[N-1][3] ^ b_reg[N-1][3] ^ slice_sum[3] ^ slice_co;
  end

  assign bus.ovf = ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed operands, monitor pops expected results on handshake.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
  } result_t;

  logic    clk = 1'b0;
  logic    reset;
  int      n_checks = 0;
  int      n_pass   = 0;
  result_t sb[$];

  nibble_serial_adder_if #(.WIDTH(WIDTH)) ifc ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // Monitor: a result is consumed on the edge following a negedge with out_valid && out_ready.
  always @(negedge clk) begin : monitor
    result_t e;
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got sum 0x%0h with no pending operation, want none", ifc.sum);
      end else begin
        e = sb.pop_front();
        check("sb_sum",   ifc.sum,   e.sum);
        check("sb_c_out", ifc.c_out, e.c_out);
        check("sb_ovf",   ifc.ovf,   e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c_in,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_co, input logic exp_ovf);
    check("in_ready_before_accept", ifc.in_ready, 1);
    sb.push_back({exp_sum, exp_co, exp_ovf & OVF_EN});
    ifc.a        = a;
    ifc.b        = b;
    ifc.c_in     = c_in;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    check("in_ready_busy", ifc.in_ready, 0);
  endtask

  task automatic wait_result();
    int cycles = 0;
    while (!ifc.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("latency", cycles, N);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c_in,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_co, input logic exp_ovf);
    ifc.out_ready = 1'b1;
    issue(a, b, c_in, exp_sum, exp_co, exp_ovf);
    wait_result();
    tick();
    check("in_ready_after_consume", ifc.in_ready, 1);
    check("out_valid_after_consume", ifc.out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    reset         = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.a         = WIDTH'($urandom);
    ifc.b         = WIDTH'($urandom);
    ifc.c_in      = 1'($urandom);
    ifc.out_ready = 1'($urandom);
    tick();
    tick();
    check("reset_in_ready",  ifc.in_ready,  1);
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_sum",       ifc.sum,       16'h0000);
    check("reset_c_out",     ifc.c_out,     0);
    check("reset_ovf",       ifc.ovf,       0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    reset         = 1'b0;
    tick();

    run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

    // Backpressure with a competing request that must wait for consumption
    ifc.out_ready = 1'b0;
    issue(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    wait_result();
    sb.push_back({16'h2222, 1'b0, 1'b0});
    ifc.a        = 16'h1111;
    ifc.b        = 16'h1111;
    ifc.c_in     = 1'b0;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", ifc.out_valid, 1);
      check("bp_in_ready",  ifc.in_ready,  0);
      check("bp_sum",       ifc.sum,       16'h2201);
      check("bp_c_out",     ifc.c_out,     0);
      check("bp_ovf",       ifc.ovf,       0);
    end
    ifc.out_ready = 1'b1;
    tick();
    check("bp_in_ready_after_consume",  ifc.in_ready,  1);
    check("bp_out_valid_after_consume", ifc.out_valid, 0);
    tick();
    ifc.in_valid = 1'b0;
    check("bp_next_accept", ifc.in_ready, 0);
    wait_result();
    tick();
    check("bp_in_ready_final", ifc.in_ready, 1);

    // Reset after two nibbles of an operation discards it
    ifc.a        = 16'hAAAA;
    ifc.b        = 16'h5555;
    ifc.c_in     = 1'b0;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_out_valid", ifc.out_valid, 0);
    check("abort_in_ready",  ifc.in_ready,  1);
    check("abort_sum",       ifc.sum,       16'h0000);
    check("abort_c_out",     ifc.c_out,     0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_out_valid", ifc.out_valid, 0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    tick();
    tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
